// File: rtl/la32_div_unit_if.sv
// rtl/la32_div_unit_if.sv - request/response bundle between the execute stage and the divider
interface la32_div_unit_if #(
  parameter int DATA_W = 32
) ();
  logic              start_i;
  logic              op_signed_i;
  logic              op_mod_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic              flush_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] result_o;

  modport master (
    output start_i, op_signed_i, op_mod_i, src1_i, src2_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_signed_i, op_mod_i, src1_i, src2_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/la32_div_unit.sv
// rtl/la32_div_unit.sv - radix-2 restoring divider for div.w/div.wu/mod.w/mod.wu, one quotient bit per cycle
// Optional DIV_ZERO_FAST_EN: a zero divisor jumps straight from IDLE to DONE.
module la32_div_unit #(
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            rst_n,
  la32_div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic              op_mod_q;
  logic              q_neg;
  logic              r_neg;
  logic              div_zero;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] src1_q;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] result_q;

  logic [DATA_W-1:0] abs1, abs2;
  logic [DATA_W:0]   partial, diff;
  logic              take;
  logic [DATA_W-1:0] step_rem, step_quo, quo_fix, rem_fix, final_res;

  assign abs1 = (bus.op_signed_i && bus.src1_i[DATA_W-1]) ? -bus.src1_i : bus.src1_i;
  assign abs2 = (bus.op_signed_i && bus.src2_i[DATA_W-1]) ? -bus.src2_i : bus.src2_i;

  // The dividend register doubles as the quotient: its MSB feeds the
  // partial remainder while the new quotient bit shifts in at the LSB.
  assign partial  = {rem, dividend[DATA_W-1]};
  assign diff     = partial - {1'b0, divisor};
  assign take     = ~diff[DATA_W];
  assign step_rem = take ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
  assign step_quo = {dividend[DATA_W-2:0], take};

  assign quo_fix   = div_zero ? {DATA_W{1'b1}} : (q_neg ? -step_quo : step_quo);
  assign rem_fix   = div_zero ? src1_q : (r_neg ? -step_rem : step_rem);
  assign final_res = op_mod_q ? rem_fix : quo_fix;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= IDLE;
      op_mod_q <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      src1_q   <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start_i && !bus.flush_i) begin
            op_mod_q <= bus.op_mod_i;
            q_neg    <= bus.op_signed_i & (bus.src1_i[DATA_W-1] ^ bus.src2_i[DATA_W-1]);
            r_neg    <= bus.op_signed_i & bus.src1_i[DATA_W-1];
            div_zero <= (bus.src2_i == '0);
            dividend <= abs1;
            divisor  <= abs2;
            rem      <= '0;
            src1_q   <= bus.src1_i;
            cnt      <= CNT_W'(DATA_W - 1);
            busy_q   <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
            if (bus.src2_i == '0) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= bus.op_mod_i ? bus.src1_i : {DATA_W{1'b1}};
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          if (bus.flush_i) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            rem      <= step_rem;
            dividend <= step_quo;
            cnt      <= cnt - 1'b1;
            if (cnt == '0) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= final_res;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_la32_div_unit.sv
// tb/tb_la32_div_unit.sv - directed vector table plus flush/restart/reset sequences for la32_div_unit
module tb_la32_div_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  la32_div_unit_if #(.DATA_W(32)) bus ();
  la32_div_unit #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    string       name;
    logic        sgn;
    logic        md;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic sgn, input logic md, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy1);
    bus.op_signed_i = sgn;
    bus.op_mod_i    = md;
    bus.src1_i      = a;
    bus.src2_i      = b;
    bus.start_i     = 1'b1;
    step();
    bus.start_i = 1'b0;
    lat   = 1;
    busy1 = bus.busy_o;
    while (!bus.done_o && lat < 100) begin
      step();
      lat++;
    end
    res = bus.result_o;
    if (!bus.done_o) lat = -1;
    step();
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          exp_lat;
    int          cyc;
    int          spur;
    int          n_done;
    int          done_cyc[3];
    logic [31:0] done_res[3];
    logic        busy1;

    vecs[0]  = '{"udiv_100_7",     1'b0, 1'b0, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{"umod_100_7",     1'b0, 1'b1, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{"smod_m7_2",      1'b1, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF};
    vecs[3]  = '{"sdiv_m7_2",      1'b1, 1'b0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD};
    vecs[4]  = '{"sdiv_ovf",       1'b1, 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000};
    vecs[5]  = '{"smod_ovf",       1'b1, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h00000000};
    vecs[6]  = '{"sdiv_zero",      1'b1, 1'b0, 32'hFFFFFFF0,   32'd0,          32'hFFFFFFFF};
    vecs[7]  = '{"smod_zero",      1'b1, 1'b1, 32'hFFFFFFF0,   32'd0,          32'hFFFFFFF0};
    vecs[8]  = '{"udiv_max_3",     1'b0, 1'b0, 32'hFFFFFFFF,   32'd3,          32'h55555555};
    vecs[9]  = '{"umod_max_3",     1'b0, 1'b1, 32'hFFFFFFFF,   32'd3,          32'h00000000};
    vecs[10] = '{"sdiv_m100_7",    1'b1, 1'b0, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2};
    vecs[11] = '{"smod_m100_7",    1'b1, 1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE};
    vecs[12] = '{"sdiv_100_m7",    1'b1, 1'b0, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2};
    vecs[13] = '{"smod_100_m7",    1'b1, 1'b1, 32'd100,        32'hFFFFFFF9,   32'd2};
    vecs[14] = '{"udiv_8000_ffff", 1'b0, 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000};
    vecs[15] = '{"umod_8000_ffff", 1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000};
    vecs[16] = '{"umod_zero",      1'b0, 1'b1, 32'd5,          32'd0,          32'd5};
    vecs[17] = '{"udiv_100_7_end", 1'b0, 1'b0, 32'd100,        32'd7,          32'd14};

    rst_n           = 1'b1;
    bus.start_i     = 1'b0;
    bus.op_signed_i = 1'b0;
    bus.op_mod_i    = 1'b0;
    bus.src1_i      = '0;
    bus.src2_i      = '0;
    bus.flush_i     = 1'b0;
    step();
    step();
    chk("reset_busy",   32'(bus.busy_o), 32'd0);
    chk("reset_done",   32'(bus.done_o), 32'd0);
    chk("reset_result", bus.result_o,    32'd0);
    rst_n = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_op(vecs[i].sgn, vecs[i].md, vecs[i].a, vecs[i].b, res, lat, busy1);
`ifdef DIV_ZERO_FAST_EN
      exp_lat = (vecs[i].b == 32'd0) ? 1 : 33;
`else
      exp_lat = 33;
`endif
      chk({vecs[i].name, "_result"}, res, vecs[i].exp);
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({vecs[i].name, "_busy_c1"}, 32'(busy1), 32'd1);
      chk({vecs[i].name, "_idle_after"}, 32'(bus.busy_o), 32'd0);
      chk({vecs[i].name, "_hold"}, bus.result_o, vecs[i].exp);
    end

    // flush together with start in IDLE: nothing accepted
    bus.src1_i  = 32'd9;
    bus.src2_i  = 32'd3;
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    chk("flush_start_idle_busy", 32'(bus.busy_o), 32'd0);
    step();

    // flush at cycle 10, restart at cycle 11, done expected in cycle 44
    bus.op_signed_i = 1'b0;
    bus.op_mod_i    = 1'b0;
    bus.src1_i      = 32'd1000;
    bus.src2_i      = 32'd10;
    bus.start_i     = 1'b1;
    step();
    bus.start_i = 1'b0;
    cyc  = 1;
    spur = 0;
    while (cyc < 10) begin
      step();
      cyc++;
      if (bus.done_o) spur++;
    end
    bus.flush_i = 1'b1;
    step();
    cyc++;
    bus.flush_i = 1'b0;
    chk("flush_busy_c11",   32'(bus.busy_o), 32'd0);
    chk("flush_done_c11",   32'(bus.done_o), 32'd0);
    chk("flush_result_c11", bus.result_o,    32'd14);
    bus.src1_i  = 32'd1000;
    bus.src2_i  = 32'd3;
    bus.start_i = 1'b1;
    step();
    cyc++;
    bus.start_i = 1'b0;
    while (!bus.done_o && cyc < 120) begin
      if (bus.result_o !== 32'd14) spur++;
      step();
      cyc++;
    end
    chk("flush_no_spurious", 32'(spur), 32'd0);
    chk("restart_done_cycle", 32'(cyc), 32'd44);
    chk("restart_result", bus.result_o, 32'd333);
    step();

    // flush in the DONE cycle: pulse already out, then IDLE
    bus.src1_i  = 32'd100;
    bus.src2_i  = 32'd7;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    cyc = 1;
    while (!bus.done_o && cyc < 100) begin
      step();
      cyc++;
    end
    chk("flush_in_done_pulse", 32'(bus.done_o), 32'd1);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    chk("flush_in_done_busy", 32'(bus.busy_o), 32'd0);
    chk("flush_in_done_result", bus.result_o, 32'd14);
    step();

    // start held high with changing operands: accepts at 0, 34, 68
    bus.op_signed_i = 1'b0;
    bus.op_mod_i    = 1'b0;
    bus.src2_i      = 32'd7;
    bus.src1_i      = 32'd1000;
    bus.start_i     = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 101; c++) begin
      step();
      bus.src1_i = 32'd1000 + 32'(c);
      if (bus.done_o) begin
        if (n_done < 3) begin
          done_cyc[n_done] = c;
          done_res[n_done] = bus.result_o;
        end
        n_done++;
      end
    end
    bus.start_i = 1'b0;
    chk("stream_done_count", 32'(n_done), 32'd3);
    if (n_done >= 3) begin
      chk("stream0_cycle",  32'(done_cyc[0]), 32'd33);
      chk("stream0_result", done_res[0],      32'd142);
      chk("stream1_cycle",  32'(done_cyc[1]), 32'd67);
      chk("stream1_result", done_res[1],      32'd147);
      chk("stream2_cycle",  32'(done_cyc[2]), 32'd101);
      chk("stream2_result", done_res[2],      32'd152);
    end
    step();
    step();

    // asynchronous reset in the middle of an operation
    bus.src1_i  = 32'd1000;
    bus.src2_i  = 32'd7;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int c = 2; c <= 5; c++) step();
    chk("pre_reset_busy", 32'(bus.busy_o), 32'd1);
    #2;
    rst_n = 1'b1;
    #1;
    chk("midrst_busy",   32'(bus.busy_o), 32'd0);
    chk("midrst_done",   32'(bus.done_o), 32'd0);
    chk("midrst_result", bus.result_o,    32'd0);
    step();
    rst_n = 1'b0;
    step();

    run_op(1'b0, 1'b1, 32'd1000, 32'd7, res, lat, busy1);
    chk("post_reset_result",  res,         32'd6);
    chk("post_reset_latency", 32'(lat),    32'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/la32_div_unit.md
# la32_div_unit

Multi-cycle 32-bit integer divider in the execute stage, downstream of instruction decode. The execute stage translates the decoded ALU op into `op_signed_i` and `op_mod_i` for div.w, div.wu, mod.w and mod.wu, starts the unit, and stalls until `done_o`. The unit uses a radix-2 restoring algorithm with one quotient bit per cycle. It is cancelled by pipeline flush on an exception, ertn or branch mispredict.

## Interface
- `DATA_W`, default 32: operand and result width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-high reset (asserted = 1).
- `start_i`  in  1  request a divide; accepted only when `busy_o`=0.
- `op_signed_i`  in  1  1 = signed (div.w/mod.w), 0 = unsigned.
- `op_mod_i`  in  1  1 = return remainder, 0 = return quotient.
- `src1_i`  in  DATA_W  dividend; sampled on the accepting edge.
- `src2_i`  in  DATA_W  divisor; sampled on the accepting edge.
- `flush_i`  in  1  abort any operation in flight.
- `busy_o`  out  1  unit not idle; reset 0.
- `done_o`  out  1  one-cycle pulse, result valid; reset 0.
- `result_o`  out  DATA_W  quotient or remainder; reset 0.

## Operation
- States: IDLE, CALC, DONE. Reset value is IDLE.
- IDLE → CALC when `start_i`=1 and `flush_i`=0.
- On the accepting edge, latch:
  - the op bits;
  - |src1| and |src2| (two's-complement absolute value when signed; raw value otherwise);
  - quotient sign = src1[31]^src2[31] (signed only);
  - remainder sign = src1[31] (signed only);
  - the zero-divisor flag;
  - an iteration counter set to DATA_W-1.
- CALC step, once per cycle:
  - partial = {rem[DATA_W-1:0], dividend_msb}, 33 bits wide;
  - if partial ≥ divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0;
  - decrement the counter.
- CALC → DONE after the step in which the counter was 0.
- DONE: `done_o`=1 and `result_o` is updated in the same cycle. Next state is IDLE unconditionally.
- Sign fix-up is applied when `result_o` is loaded:
  - signed quotient is negated if the quotient sign is 1;
  - signed remainder is negated if the remainder sign is 1.
- Divide by zero, any signedness: quotient = 0xFFFFFFFF, remainder = `src1_i` exactly as input. This overrides the fix-up.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This falls out of the natural 33-bit arithmetic.
- `busy_o` = (state != IDLE).
- `result_o` holds its value until the next DONE. It is not cleared on start or on flush.
- `start_i` while `busy_o`=1 is ignored. No queuing.
- `flush_i`=1 in any state forces IDLE on the next edge, and no `done_o` is produced.
- `flush_i` together with `start_i` in IDLE: flush wins and the request is not accepted.
- `flush_i` in the DONE cycle: `done_o` still pulses that cycle (it is already registered), then IDLE.
- Reset mid-operation: immediate return to IDLE; all outputs 0.

## Timing
- Cycle 0: `start_i` is accepted.
- Cycles 1..DATA_W: CALC, with `busy_o`=1.
- Cycle DATA_W+1 (33): DONE, with `done_o`=1, `busy_o`=1 and `result_o` valid.
- Cycle 34: IDLE. This is the earliest cycle a new start can be accepted, giving a 34-cycle issue interval.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `DIV_ZERO_FAST_EN`.
- Defined: a zero divisor detected at acceptance skips CALC. IDLE → DONE, so `done_o` appears in cycle 1 with the divide-by-zero result values.
- Undefined: a zero divisor runs the full DATA_W iterations and `done_o` appears in cycle 33. Result values are identical.

## Test plan
- Unsigned div 100 / 7: start at cycle 0 → `done_o` in cycle 33 with `result_o`=14. With `op_mod_i`=1 → 2.
- Signed mod -7 % 2 (0xFFFFFFF9, 2) → `result_o`=0xFFFFFFFF. Signed div → 0xFFFFFFFD.
- Signed overflow, 0x80000000 / 0xFFFFFFFF → quotient 0x80000000. Mod → 0.
- Divide by zero, signed, 0xFFFFFFF0 / 0 → quotient 0xFFFFFFFF, mod 0xFFFFFFF0. `done_o` in cycle 33, or in cycle 1 with `DIV_ZERO_FAST_EN`.
- Flush at cycle 10 → `busy_o`=0 in cycle 11, no `done_o`, `result_o` unchanged. A new start at cycle 11 completes in cycle 44.
- `start_i` held high continuously with changing operands → accepts only at cycles 0, 34, 68…, each result matches the operands sampled at its acceptance. Asserting `rst_n` at cycle 5 drives all outputs to 0 at once.
